// File: rtl/cache_control.sv
// Control FSM for the 2-way set-associative write-back/write-allocate cache.
// Sequences hit service, dirty-victim writeback and line fill; keeps saturating stats.
module cache_control #(
    parameter int s_cnt = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    output logic             mem_resp,
    input  logic             hit,
    input  logic             way_0_hit,
    input  logic             way_1_hit,
    input  logic             way_0_valid_out,
    input  logic             way_1_valid_out,
    input  logic             way_0_dirty_out,
    input  logic             way_1_dirty_out,
    input  logic             lru_out,
    input  logic             pmem_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic             ld_way_0_valid,
    output logic             way_0_valid_in,
    output logic             ld_way_1_valid,
    output logic             way_1_valid_in,
    output logic             ld_way_0_dirty,
    output logic             way_0_dirty_in,
    output logic             ld_way_1_dirty,
    output logic             way_1_dirty_in,
    output logic             ld_way_0_tag,
    output logic             ld_way_1_tag,
    output logic [1:0]       way_0_w_en_mux_sel,
    output logic [1:0]       way_1_w_en_mux_sel,
    output logic             way_0_data_in_mux_sel,
    output logic             way_1_data_in_mux_sel,
    output logic             ld_lru,
    output logic             lru_in,
    output logic             pmem_addr_mux_sel,
    output logic [s_cnt-1:0] hit_count,
    output logic [s_cnt-1:0] miss_count,
    output logic [s_cnt-1:0] wb_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_WB    = 2'd2;
    localparam logic [1:0] S_FILL  = 2'd3;

    localparam logic [1:0] WEN_NONE = 2'b00;
    localparam logic [1:0] WEN_ALL  = 2'b01;
    localparam logic [1:0] WEN_CPU  = 2'b10;

    localparam logic [s_cnt-1:0] CNT_MAX = '1;

    logic [1:0]       state_q, state_d;
    logic             victim_q, victim_d;
    logic [s_cnt-1:0] hit_q, hit_d;
    logic [s_cnt-1:0] miss_q, miss_d;
    logic [s_cnt-1:0] wb_q, wb_d;

    logic req, is_write, victim_dirty;

    assign req      = mem_read | mem_write;
    assign is_write = mem_write;
    assign victim_dirty = lru_out ? (way_1_valid_out & way_1_dirty_out)
                                  : (way_0_valid_out & way_0_dirty_out);

    always_comb begin
        state_d  = state_q;
        victim_d = victim_q;
        hit_d    = hit_q;
        miss_d   = miss_q;
        wb_d     = wb_q;

        mem_resp              = 1'b0;
        pmem_read             = 1'b0;
        pmem_write            = 1'b0;
        ld_way_0_valid        = 1'b0;
        way_0_valid_in        = 1'b0;
        ld_way_1_valid        = 1'b0;
        way_1_valid_in        = 1'b0;
        ld_way_0_dirty        = 1'b0;
        way_0_dirty_in        = 1'b0;
        ld_way_1_dirty        = 1'b0;
        way_1_dirty_in        = 1'b0;
        ld_way_0_tag          = 1'b0;
        ld_way_1_tag          = 1'b0;
        way_0_w_en_mux_sel    = WEN_NONE;
        way_1_w_en_mux_sel    = WEN_NONE;
        way_0_data_in_mux_sel = 1'b0;
        way_1_data_in_mux_sel = 1'b0;
        ld_lru                = 1'b0;
        lru_in                = 1'b0;
        pmem_addr_mux_sel     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (!req) begin
                    state_d = S_IDLE;
                end else if (hit) begin
                    mem_resp = 1'b1;
                    ld_lru   = 1'b1;
                    // LRU bit names the victim, so point it at the way not just used
                    lru_in   = way_0_hit;
                    if (hit_q != CNT_MAX) hit_d = hit_q + 1'b1;
                    if (is_write) begin
                        if (way_0_hit) begin
                            way_0_w_en_mux_sel = WEN_CPU;
                            ld_way_0_dirty     = 1'b1;
                            way_0_dirty_in     = 1'b1;
                        end
                        if (way_1_hit) begin
                            way_1_w_en_mux_sel = WEN_CPU;
                            ld_way_1_dirty     = 1'b1;
                            way_1_dirty_in     = 1'b1;
                        end
                    end
                    state_d = S_IDLE;
                end else begin
                    victim_d = lru_out;
                    if (miss_q != CNT_MAX) miss_d = miss_q + 1'b1;
                    if (victim_dirty) begin
                        if (wb_q != CNT_MAX) wb_d = wb_q + 1'b1;
                        state_d = S_WB;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_WB: begin
                pmem_write        = 1'b1;
                pmem_addr_mux_sel = 1'b1;
                if (pmem_resp) state_d = S_FILL;
            end
            S_FILL: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    // Install the line into the registered victim; re-check then hits
                    if (victim_q) begin
                        way_1_w_en_mux_sel    = WEN_ALL;
                        way_1_data_in_mux_sel = 1'b1;
                        ld_way_1_tag          = 1'b1;
                        ld_way_1_valid        = 1'b1;
                        way_1_valid_in        = 1'b1;
                        ld_way_1_dirty        = 1'b1;
                    end else begin
                        way_0_w_en_mux_sel    = WEN_ALL;
                        way_0_data_in_mux_sel = 1'b1;
                        ld_way_0_tag          = 1'b1;
                        ld_way_0_valid        = 1'b1;
                        way_0_valid_in        = 1'b1;
                        ld_way_0_dirty        = 1'b1;
                    end
                    state_d = S_CHECK;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            victim_q <= 1'b0;
            hit_q    <= '0;
            miss_q   <= '0;
            wb_q     <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            wb_q     <= wb_d;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
    assign wb_count   = wb_q;

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control: fill, write hit, writeback, dropped request,
// reset mid-writeback and counter saturation (counters built 2 bits wide).
module tb_cache_control;

    localparam int SC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_read = 0, mem_write = 0, hit = 0, way_0_hit = 0, way_1_hit = 0;
    logic way_0_valid_out = 0, way_1_valid_out = 0, way_0_dirty_out = 0, way_1_dirty_out = 0;
    logic lru_out = 0, pmem_resp = 0;
    logic mem_resp, pmem_read, pmem_write;
    logic ld_way_0_valid, way_0_valid_in, ld_way_1_valid, way_1_valid_in;
    logic ld_way_0_dirty, way_0_dirty_in, ld_way_1_dirty, way_1_dirty_in;
    logic ld_way_0_tag, ld_way_1_tag;
    logic [1:0] way_0_w_en_mux_sel, way_1_w_en_mux_sel;
    logic way_0_data_in_mux_sel, way_1_data_in_mux_sel, ld_lru, lru_in, pmem_addr_mux_sel;
    logic [SC-1:0] hit_count, miss_count, wb_count;

    int errors = 0;
    int checks = 0;

    cache_control #(.s_cnt(SC)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .hit(hit), .way_0_hit(way_0_hit), .way_1_hit(way_1_hit),
        .way_0_valid_out(way_0_valid_out), .way_1_valid_out(way_1_valid_out),
        .way_0_dirty_out(way_0_dirty_out), .way_1_dirty_out(way_1_dirty_out),
        .lru_out(lru_out), .pmem_resp(pmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .ld_way_0_valid(ld_way_0_valid), .way_0_valid_in(way_0_valid_in),
        .ld_way_1_valid(ld_way_1_valid), .way_1_valid_in(way_1_valid_in),
        .ld_way_0_dirty(ld_way_0_dirty), .way_0_dirty_in(way_0_dirty_in),
        .ld_way_1_dirty(ld_way_1_dirty), .way_1_dirty_in(way_1_dirty_in),
        .ld_way_0_tag(ld_way_0_tag), .ld_way_1_tag(ld_way_1_tag),
        .way_0_w_en_mux_sel(way_0_w_en_mux_sel), .way_1_w_en_mux_sel(way_1_w_en_mux_sel),
        .way_0_data_in_mux_sel(way_0_data_in_mux_sel), .way_1_data_in_mux_sel(way_1_data_in_mux_sel),
        .ld_lru(ld_lru), .lru_in(lru_in), .pmem_addr_mux_sel(pmem_addr_mux_sel),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs are changed 2 time units after the edge; checks follow a 1-unit settle.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_pmem_read", pmem_read, 0);
        chk("rst_pmem_write", pmem_write, 0);
        chk("rst_mem_resp", mem_resp, 0);
        chk("rst_w_en0", way_0_w_en_mux_sel, 0);
        chk("rst_hit_cnt", hit_count, 0);
        #10 rst = 1'b0;
        tick();

        // Read miss, both ways invalid, fill way 0
        mem_read = 1; lru_out = 0;
        #1 chk("idle_no_resp", mem_resp, 0);
        tick();
        #1 chk("chk_miss_no_resp", mem_resp, 0);
        chk("chk_miss_no_ldlru", ld_lru, 0);
        tick();
        #1 chk("fill_pmem_read", pmem_read, 1);
        chk("fill_addr_sel", pmem_addr_mux_sel, 0);
        chk("fill_no_write", pmem_write, 0);
        chk("miss_cnt_1", miss_count, 1);
        chk("hit_cnt_0", hit_count, 0);
        for (int i = 0; i < 4; i++) tick();
        #1 chk("fill_wait_read", pmem_read, 1);
        chk("fill_wait_no_wen", way_0_w_en_mux_sel, 0);
        pmem_resp = 1;
        #1 chk("fill0_wen", way_0_w_en_mux_sel, 2'b01);
        chk("fill0_ldtag", ld_way_0_tag, 1);
        chk("fill0_valid_in", way_0_valid_in, 1);
        chk("fill0_ld_valid", ld_way_0_valid, 1);
        chk("fill0_dmux", way_0_data_in_mux_sel, 1);
        chk("fill0_ld_dirty", ld_way_0_dirty, 1);
        chk("fill0_dirty_in", way_0_dirty_in, 0);
        chk("fill0_way1_wen", way_1_w_en_mux_sel, 0);
        tick();
        pmem_resp = 0; hit = 1; way_0_hit = 1; way_0_valid_out = 1;
        #1 chk("recheck_resp", mem_resp, 1);
        chk("recheck_ldlru", ld_lru, 1);
        chk("recheck_lru_in", lru_in, 1);
        chk("recheck_no_pmem", pmem_read, 0);
        tick();
        mem_read = 0; hit = 0; way_0_hit = 0;
        #1 chk("after_fill_resp", mem_resp, 0);
        chk("after_fill_miss", miss_count, 1);
        chk("after_fill_hit", hit_count, 1);

        // Write hit way 1
        mem_write = 1; hit = 1; way_1_hit = 1; way_1_valid_out = 1;
        #1 chk("wr_idle_resp", mem_resp, 0);
        tick();
        #1 chk("wr_resp", mem_resp, 1);
        chk("wr_wen1", way_1_w_en_mux_sel, 2'b10);
        chk("wr_wen0", way_0_w_en_mux_sel, 2'b00);
        chk("wr_ld_dirty1", ld_way_1_dirty, 1);
        chk("wr_dirty_in1", way_1_dirty_in, 1);
        chk("wr_dmux1", way_1_data_in_mux_sel, 0);
        chk("wr_lru_in", lru_in, 0);
        tick();
        mem_write = 0; hit = 0; way_1_hit = 0;
        #1 chk("wr_done_resp", mem_resp, 0);
        chk("wr_hit_cnt", hit_count, 2);

        // Read miss with dirty victim in way 1 -> writeback then fill
        mem_read = 1; lru_out = 1; way_1_dirty_out = 1;
        tick();
        #1 chk("wb_chk_resp", mem_resp, 0);
        tick();
        lru_out = 0;  // victim must come from the registered copy
        #1 chk("wb_pmem_write", pmem_write, 1);
        chk("wb_addr_sel", pmem_addr_mux_sel, 1);
        chk("wb_no_read", pmem_read, 0);
        chk("wb_cnt_1", wb_count, 1);
        chk("wb_miss_cnt", miss_count, 2);
        tick(); tick();
        #1 chk("wb_hold_write", pmem_write, 1);
        pmem_resp = 1;
        tick();
        pmem_resp = 0;
        #1 chk("wbfill_read", pmem_read, 1);
        chk("wbfill_no_write", pmem_write, 0);
        chk("wbfill_addr_sel", pmem_addr_mux_sel, 0);
        pmem_resp = 1;
        #1 chk("fill1_wen", way_1_w_en_mux_sel, 2'b01);
        chk("fill1_ldtag", ld_way_1_tag, 1);
        chk("fill1_dirty_in", way_1_dirty_in, 0);
        chk("fill1_way0_wen", way_0_w_en_mux_sel, 0);
        chk("fill1_way0_tag", ld_way_0_tag, 0);
        tick();
        pmem_resp = 0; way_1_dirty_out = 0; hit = 1; way_1_hit = 1;
        #1 chk("wb_recheck_resp", mem_resp, 1);
        chk("wb_recheck_lru_in", lru_in, 0);
        tick();
        mem_read = 0; hit = 0; way_1_hit = 0;
        #1 chk("wb_hit_cnt", hit_count, 3);

        // Request dropped during fill: completes, no mem_resp
        mem_read = 1; lru_out = 0; way_0_valid_out = 0;
        tick(); tick();
        #1 chk("drop_fill_read", pmem_read, 1);
        chk("drop_miss_sat", miss_count, 3);
        mem_read = 0;
        #1 chk("drop_still_read", pmem_read, 1);
        pmem_resp = 1;
        tick();
        pmem_resp = 0;
        #1 chk("drop_check_resp", mem_resp, 0);
        chk("drop_check_ldlru", ld_lru, 0);
        tick();
        #1 chk("drop_idle_read", pmem_read, 0);
        chk("drop_idle_resp", mem_resp, 0);
        chk("drop_hit_cnt", hit_count, 3);

        // Reset asserted in writeback
        mem_read = 1; lru_out = 0; way_0_valid_out = 1; way_0_dirty_out = 1;
        tick(); tick();
        #1 chk("rwb_write", pmem_write, 1);
        chk("rwb_wb_cnt", wb_count, 2);
        rst = 1;
        #1 chk("rwb_write_drop", pmem_write, 0);
        chk("rwb_hit_zero", hit_count, 0);
        chk("rwb_miss_zero", miss_count, 0);
        chk("rwb_wb_zero", wb_count, 0);
        mem_read = 0; way_0_dirty_out = 0;
        tick();
        rst = 0;
        tick();
        #1 chk("rwb_idle_read", pmem_read, 0);
        chk("rwb_idle_write", pmem_write, 0);

        // Five hits saturate the 2-bit hit counter; last one has read+write (treated as write)
        for (int i = 0; i < 5; i++) begin
            mem_read = 1; mem_write = (i == 4); hit = 1; way_0_hit = 1;
            tick();
            #1 chk("sat_resp", mem_resp, 1);
            if (i == 4) chk("rdwr_is_write", way_0_w_en_mux_sel, 2'b10);
            tick();
            mem_read = 0; mem_write = 0; hit = 0; way_0_hit = 0;
            #1 chk("sat_hit_cnt", hit_count, (i < 3) ? i + 1 : 3);
        end
        chk("sat_miss_cnt", miss_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        errors++;
        $display("FAIL timeout");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
